branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch controller: 2-bit saturating BHT prediction at decode, branch
// resolution in EX, mispredict redirect/flush sequencing and perf counters.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   stall               - global pipeline stall, freezes all state except FLUSH->IDLE
//   id_valid/id_inst/id_pc - decode-stage instruction
//   BrEq, BrLt          - EX comparator results
//   pred_taken          - decode-stage prediction (combinational)
//   BrUn                - comparator mode for EX: 0 unsigned, 1 signed (combinational)
//   redirect            - EX mispredict (combinational)
//   redirect_sel        - 1: branch target, 0: ex_pc+4 (combinational)
//   flush               - squash younger instructions (combinational)
//   br_count            - resolved-branch counter, saturating
//   mispred_count       - mispredict counter, saturating
module branch_ctrl #(
  parameter int unsigned BHT_IDX_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      id_pc,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             pred_taken,
  output logic             BrUn,
  output logic             redirect,
  output logic             redirect_sel,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned BHT_N      = 1 << BHT_IDX_W;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_branch;
    logic [2:0]           funct3;
    logic [BHT_IDX_W-1:0] idx;
    logic                 pred;
  } idex_t;

  logic [1:0]           r_bht [BHT_N];
  idex_t                r_idex;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_br_count;
  logic [CNT_W-1:0]     r_mispred_count;

  logic                 w_id_branch;
  logic [BHT_IDX_W-1:0] w_id_idx;
  logic                 w_id_pred;
  logic                 w_ex_br;
  logic                 w_taken;
  logic                 w_redirect;
  logic [1:0]           w_bht_cur;
  logic [1:0]           w_bht_nxt;
  logic                 w_unused;

  // Instruction/PC bits the controller never looks at.
  assign w_unused = ^{id_inst[31:15], id_inst[11:7], id_pc[31:BHT_IDX_W+2], id_pc[1:0]};

  // Decode-stage lookup; reads the pre-update table on an index collision.
  assign w_id_branch = id_valid & (id_inst[6:0] == OPC_BRANCH);
  assign w_id_idx    = id_pc[BHT_IDX_W+1:2];
  assign w_id_pred   = w_id_branch & r_bht[w_id_idx][1];
  assign pred_taken  = rst_n & w_id_pred;

  // EX resolution.
  assign w_ex_br = r_idex.valid & r_idex.is_branch;

  always_comb begin
    w_taken = 1'b0;
    case (r_idex.funct3)
      3'b000:         w_taken = BrEq;
      3'b001:         w_taken = ~BrEq;
      3'b100, 3'b110: w_taken = BrLt;
      3'b101, 3'b111: w_taken = ~BrLt;
      default:        w_taken = 1'b0;
    endcase
  end

  // Unsigned compare only for a live BLTU/BGEU; signed in every other case.
  assign BrUn = ~rst_n | ~(w_ex_br & (r_idex.funct3[2:1] == 2'b11));

  assign w_redirect   = rst_n & ~stall & w_ex_br & (w_taken != r_idex.pred);
  assign redirect     = w_redirect;
  assign redirect_sel = w_taken;
  assign flush        = rst_n & (w_redirect | (r_state == S_FLUSH));

  // Flush sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Flush sequencer next state; FLUSH always completes regardless of stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_redirect) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ID->EX pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex <= '0;
    end else if (!stall) begin
      if (flush) begin
        r_idex <= '0;
      end else begin
        r_idex.valid     <= id_valid;
        r_idex.is_branch <= w_id_branch;
        r_idex.funct3    <= id_inst[14:12];
        r_idex.idx       <= w_id_idx;
        r_idex.pred      <= w_id_pred;
      end
    end
  end

  // Saturating 2-bit counter update for the resolving branch.
  assign w_bht_cur = r_bht[r_idex.idx];

  always_comb begin
    w_bht_nxt = w_bht_cur;
    if (w_taken) begin
      if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'd1;
    end else begin
      if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (!stall && w_ex_br) begin
      r_bht[r_idex.idx] <= w_bht_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (!stall && w_ex_br && (r_br_count != '1))
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_redirect && (r_mispred_count != '1))
        r_mispred_count <= r_mispred_count + CNT_W'(1);
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus random traffic, checked
// through an expectation queue against a cycle-level behavioural model.
module tb_branch_ctrl;

  localparam int unsigned IDXW = 4;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          rst_n, stall, id_valid, BrEq, BrLt;
  logic [31:0]   id_inst, id_pc;
  logic          pred_taken, BrUn, redirect, redirect_sel, flush;
  logic [CW-1:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_IDX_W(IDXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .BrEq(BrEq), .BrLt(BrLt),
    .pred_taken(pred_taken), .BrUn(BrUn), .redirect(redirect),
    .redirect_sel(redirect_sel), .flush(flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {
    int pred, brun, redir, rsel, flush, brc, mpc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model state: plain integers, the table as counters 0..3.
  int bht [16];
  bit ex_v, ex_b, ex_p;
  int ex_f3, ex_idx;
  bit flush_pend;
  int brc, mpc;

  function automatic bit resolve(int f3, bit eq, bit lt);
    case (f3)
      0:       return eq;
      1:       return !eq;
      4, 6:    return lt;
      5, 7:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] br(int f3);
    logic [2:0] f = 3'(f3);
    return {17'h0, f, 5'h0, 7'b1100011};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht[i] = 1;
    ex_v = 0; ex_b = 0; ex_p = 0; ex_f3 = 0; ex_idx = 0;
    flush_pend = 0; brc = 0; mpc = 0;
  endtask

  // Apply one cycle of stimulus, queue its expected response, advance the model.
  task automatic step(input bit rst, input bit st, input bit v,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input bit eq, input bit lt);
    exp_t e;
    bit   isbr, tk, rd;
    int   idx;
    rst_n = rst; stall = st; id_valid = v; id_inst = inst; id_pc = pc;
    BrEq = eq; BrLt = lt;
    isbr = v && (inst[6:0] == 7'b1100011);
    idx  = int'(pc >> 2) % 16;
    tk   = resolve(ex_f3, eq, lt);
    rd   = rst && !st && ex_v && ex_b && (tk != ex_p);
    e.pred  = (rst && isbr && bht[idx] >= 2) ? 1 : 0;
    e.brun  = (rst && ex_v && ex_b && (ex_f3 == 6 || ex_f3 == 7)) ? 0 : 1;
    e.redir = rd ? 1 : 0;
    e.rsel  = tk ? 1 : 0;
    e.flush = (rst && (rd || flush_pend)) ? 1 : 0;
    e.brc   = brc;
    e.mpc   = mpc;
    sb.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      flush_pend = rd;
      if (!st) begin
        if (ex_v && ex_b) begin
          bht[ex_idx] = tk ? ((bht[ex_idx] + 1 > 3) ? 3 : bht[ex_idx] + 1)
                           : ((bht[ex_idx] - 1 < 0) ? 0 : bht[ex_idx] - 1);
          if (brc < CMAX) brc++;
        end
        if (rd && mpc < CMAX) mpc++;
        if (e.flush == 1) begin
          ex_v = 0;
        end else begin
          ex_v = v; ex_b = isbr; ex_f3 = int'(inst[14:12]);
          ex_idx = idx; ex_p = (e.pred == 1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit eq, input bit lt);
    step(1, 0, 0, 32'h0000_0013, 32'h0, eq, lt);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pred_taken", int'(pred_taken), e.pred);
      chk("BrUn", int'(BrUn), e.brun);
      chk("redirect", int'(redirect), e.redir);
      if (e.redir == 1) chk("redirect_sel", int'(redirect_sel), e.rsel);
      chk("flush", int'(flush), e.flush);
      chk("br_count", int'(br_count), e.brc);
      chk("mispred_count", int'(mispred_count), e.mpc);
    end
  end

  initial begin
    // First reset edge is driven without an expectation: registers are unknown.
    rst_n = 0; stall = 0; id_valid = 0; id_inst = '0; id_pc = '0; BrEq = 0; BrLt = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset hold
    step(0, 0, 1, br(0), 32'h40, 1, 1);

    // Cold predict: BEQ at 0x40 mispredicted taken
    step(1, 0, 1, br(0), 32'h40, 0, 0);
    idle(1, 0);
    idle(0, 0);
    idle(0, 0);

    // Training and saturation of index 1 with BNE
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, br(1), 32'h44, 0, 0);
      idle(0, 0);
      idle(0, 0);
    end

    // Unsigned select: BLTU taken, then BGE
    step(1, 0, 1, br(6), 32'h48, 0, 0);
    idle(0, 1);
    idle(0, 0);
    idle(0, 0);
    step(1, 0, 1, br(5), 32'h4c, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Same-index collision between EX update and ID lookup
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 1, br(0), 32'h40, 0, 0);
    step(1, 0, 1, br(0), 32'h80, 1, 0);
    idle(0, 0);
    idle(0, 0);
    step(1, 0, 1, br(0), 32'h80, 0, 0);
    idle(1, 0);
    idle(0, 0);

    // Stall freeze with a mispredicting branch in EX
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 1, br(0), 32'h40, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, br(1), 32'h44, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);
    idle(0, 0);
    idle(0, 0);

    // Reset in the middle of a flush
    step(1, 0, 1, br(0), 32'h40, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    idle(0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 1, br(4), 32'(i * 4), 0, 0);
    idle(0, 0);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] r, inst, pc;
      bit rs, st, v;
      r  = $urandom();
      rs = ($urandom_range(0, 299) != 0);
      st = ($urandom_range(0, 4) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) inst = {r[31:15], 3'($urandom_range(0, 7)), r[11:7], 7'b1100011};
      else begin
        inst = r;
        if (inst[6:0] == 7'b1100011) inst[0] = 1'b0;
      end
      pc = 32'($urandom_range(0, 63)) << 2;
      step(rs, st, v, inst, pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    idle(0, 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
